// File: rtl/hwag_coil_pkg.sv
// Shared types and defaults for the per-coil output scheduler.
package hwag_coil_pkg;

   // Coil channel FSM states; the numeric values are visible on state_o.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      CHARGE = 2'd2
   } coil_state_t;

   // Highest legal angle value; the slave angle counter wraps from here to 0.
   localparam int ACNT_TOP_DEFAULT       = 3839;
   // Maximum charge time in clk cycles (8 ms at 50 MHz).
   localparam int MAX_DWELL_CLKS_DEFAULT = 400000;

   // An angle operand is usable only if the angle counter can actually reach it.
   function automatic logic angle_ok(input logic [31:0] angle, input logic [31:0] top);
      return (angle <= top);
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Clearable, saturating up-counter measuring how long the coil has been charging.
// tc flags the last permitted charge cycle (count == TC_VALUE).
module dwell_timer #(
   parameter int WIDTH    = 24,
   parameter int TC_VALUE = 399999
) (
   input  logic clk,
   input  logic nrst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [WIDTH-1:0] TC_COUNT = WIDTH'(TC_VALUE);

   logic [WIDTH-1:0] count_reg;

   // Count charge cycles; clear has priority and the count holds at terminal count.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (en && (count_reg != TC_COUNT)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign tc = (count_reg == TC_COUNT);

endmodule

// File: rtl/coil_channel_sched.sv
// Per-coil output scheduler: double-buffers charge/ignition angle pairs, drives the
// coil from angle counter matches, enforces a max-dwell timeout and reports sparks.
module coil_channel_sched
   import hwag_coil_pkg::*;
#(
   parameter int ACNT_WIDTH      = 24,
   parameter int ACNT_TOP        = ACNT_TOP_DEFAULT,
   parameter int DWELL_WIDTH     = 24,
   parameter int MAX_DWELL_CLKS  = MAX_DWELL_CLKS_DEFAULT,
   parameter int SPARK_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       run,
   input  logic                       acnt_vld,
   input  logic [ACNT_WIDTH-1:0]      acnt,
   input  logic                       upd_stb,
   input  logic [ACNT_WIDTH-1:0]      charge_angle,
   input  logic [ACNT_WIDTH-1:0]      ignition_angle,
   input  logic                       fault_clr,
   output logic                       coil_out,
   output logic                       spark_pulse,
   output logic [SPARK_CNT_WIDTH-1:0] spark_cnt,
   output logic                       dwell_fault,
   output logic                       cfg_err,
   output logic [1:0]                 state_o
);

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_ARMED  = ARMED;
   localparam logic [1:0] ST_CHARGE = CHARGE;

   logic [1:0]                 state_reg, state_next;
   logic                       coil_reg;
   logic                       spark_reg;
   logic [SPARK_CNT_WIDTH-1:0] spark_cnt_reg;
   logic                       dwell_fault_reg;
   logic                       cfg_err_reg;

   logic [ACNT_WIDTH-1:0]      pend_charge_reg, pend_ign_reg;
   logic                       pend_vld_reg;
   logic [ACNT_WIDTH-1:0]      act_charge_reg, act_ign_reg;
   logic                       act_vld_reg;

   logic pair_ok, accept, reject, transfer, act_vld_next;
   logic charge_hit, ign_hit;
   logic dwell_tc, do_spark, do_timeout;

   // Angle pair validation, shadow transfer condition and counter match decode.
   always_comb begin
      pair_ok      = angle_ok(32'(charge_angle), 32'(ACNT_TOP)) &&
                     angle_ok(32'(ignition_angle), 32'(ACNT_TOP)) &&
                     (charge_angle != ignition_angle);
      accept       = upd_stb && pair_ok;
      reject       = upd_stb && !pair_ok;
      // Only swap in a new pair while the coil is off and no capture is in flight.
      transfer     = (state_reg == ST_IDLE) && pend_vld_reg && !upd_stb;
      act_vld_next = act_vld_reg || transfer;
      charge_hit   = acnt_vld && (acnt == act_charge_reg);
      ign_hit      = acnt_vld && (acnt == act_ignition_sel());
   end

   function automatic logic [ACNT_WIDTH-1:0] act_ignition_sel();
      return act_ign_reg;
   endfunction

   dwell_timer #(
      .WIDTH    (DWELL_WIDTH),
      .TC_VALUE (MAX_DWELL_CLKS - 1)
   ) u_dwell_timer (
      .clk  (clk),
      .nrst (nrst),
      .clr  (state_reg != ST_CHARGE),
      .en   (state_reg == ST_CHARGE),
      .tc   (dwell_tc)
   );

   // Next-state logic; an ignition match wins over a simultaneous dwell timeout.
   always_comb begin
      state_next = ST_IDLE;
      do_spark   = 1'b0;
      do_timeout = 1'b0;
      if (run) begin
         case (state_reg)
            ST_IDLE: begin
               // Matches seen in this cycle are deliberately not acted on.
               state_next = act_vld_next ? ST_ARMED : ST_IDLE;
            end
            ST_ARMED: begin
               if (pend_vld_reg) begin
                  state_next = ST_IDLE;
               end else if (charge_hit) begin
                  state_next = ST_CHARGE;
               end else begin
                  state_next = ST_ARMED;
               end
            end
            ST_CHARGE: begin
               if (ign_hit) begin
                  state_next = ST_IDLE;
                  do_spark   = 1'b1;
               end else if (dwell_tc) begin
                  state_next = ST_IDLE;
                  do_timeout = 1'b1;
               end else begin
                  state_next = ST_CHARGE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // FSM state and registered coil drive / spark reporting.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg     <= ST_IDLE;
         coil_reg      <= 1'b0;
         spark_reg     <= 1'b0;
         spark_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         coil_reg  <= (state_next == ST_CHARGE);
         spark_reg <= do_spark;
         if (do_spark) begin
            spark_cnt_reg <= spark_cnt_reg + 1'b1;
         end
      end
   end

   // Sticky fault flags; a new fault in the same cycle overrides the clear.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         dwell_fault_reg <= 1'b0;
         cfg_err_reg     <= 1'b0;
      end else begin
         if (do_timeout) begin
            dwell_fault_reg <= 1'b1;
         end else if (fault_clr) begin
            dwell_fault_reg <= 1'b0;
         end
         if (reject) begin
            cfg_err_reg <= 1'b1;
         end else if (fault_clr) begin
            cfg_err_reg <= 1'b0;
         end
      end
   end

   // Pending shadow: the last accepted pair wins; emptied when it moves to active.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pend_charge_reg <= '0;
         pend_ign_reg    <= '0;
         pend_vld_reg    <= 1'b0;
      end else if (accept) begin
         pend_charge_reg <= charge_angle;
         pend_ign_reg    <= ignition_angle;
         pend_vld_reg    <= 1'b1;
      end else if (transfer) begin
         pend_vld_reg    <= 1'b0;
      end
   end

   // Active pair used for matching; only changes while the coil is off.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         act_charge_reg <= '0;
         act_ign_reg    <= '0;
         act_vld_reg    <= 1'b0;
      end else if (transfer) begin
         act_charge_reg <= pend_charge_reg;
         act_ign_reg    <= pend_ign_reg;
         act_vld_reg    <= 1'b1;
      end
   end

   assign coil_out    = coil_reg;
   assign spark_pulse = spark_reg;
   assign spark_cnt   = spark_cnt_reg;
   assign dwell_fault = dwell_fault_reg;
   assign cfg_err     = cfg_err_reg;
   assign state_o     = state_reg;

endmodule

// File: tb/tb_coil_channel_sched.sv
// Directed bench for coil_channel_sched: a default instance plus a short-dwell instance.
module tb_coil_channel_sched;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        run = 1'b0;
   logic        acnt_vld = 1'b0;
   logic [23:0] acnt = '0;
   logic        upd_stb = 1'b0;
   logic [23:0] charge_angle = '0;
   logic [23:0] ignition_angle = '0;
   logic        fault_clr = 1'b0;

   logic        coil_out, spark_pulse, dwell_fault, cfg_err;
   logic [15:0] spark_cnt;
   logic [1:0]  state_o;

   logic        md_coil_out, md_spark_pulse, md_dwell_fault, md_cfg_err;
   logic [15:0] md_spark_cnt;
   logic [1:0]  md_state_o;

   int checks = 0;
   int errors = 0;

   coil_channel_sched dut (
      .clk(clk), .nrst(nrst), .run(run), .acnt_vld(acnt_vld), .acnt(acnt),
      .upd_stb(upd_stb), .charge_angle(charge_angle), .ignition_angle(ignition_angle),
      .fault_clr(fault_clr), .coil_out(coil_out), .spark_pulse(spark_pulse),
      .spark_cnt(spark_cnt), .dwell_fault(dwell_fault), .cfg_err(cfg_err),
      .state_o(state_o)
   );

   coil_channel_sched #(.MAX_DWELL_CLKS(50)) dut_md (
      .clk(clk), .nrst(nrst), .run(run), .acnt_vld(acnt_vld), .acnt(acnt),
      .upd_stb(upd_stb), .charge_angle(charge_angle), .ignition_angle(ignition_angle),
      .fault_clr(fault_clr), .coil_out(md_coil_out), .spark_pulse(md_spark_pulse),
      .spark_cnt(md_spark_cnt), .dwell_fault(md_dwell_fault), .cfg_err(md_cfg_err),
      .state_o(md_state_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nrst = 1'b0; run = 1'b0; acnt_vld = 1'b0; acnt = '0; upd_stb = 1'b0;
      charge_angle = '0; ignition_angle = '0; fault_clr = 1'b0;
      tick();
      tick();
      nrst = 1'b1;
   endtask

   // Present one angle pair for a single clk with run asserted.
   task automatic load_pair(input logic [23:0] c, input logic [23:0] i);
      run = 1'b1;
      charge_angle = c;
      ignition_angle = i;
      upd_stb = 1'b1;
      tick();
      upd_stb = 1'b0;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      tick();
      tick();
      checks++;
      if ({coil_out, spark_pulse, spark_cnt, dwell_fault, cfg_err, state_o} !== 21'd0) begin
         errors++;
         $display("FAIL reset_outputs: got coil=%b spk=%b cnt=%0d df=%b ce=%b st=%0d, want all 0",
                  coil_out, spark_pulse, spark_cnt, dwell_fault, cfg_err, state_o);
      end
      nrst = 1'b1;
      run = 1'b1;
      tick();
      tick();
      checks++;
      if (state_o !== 2'd0) begin
         errors++;
         $display("FAIL reset_idle_no_pair: state=%0d, want 0", state_o);
      end
      $display("test_reset: done");
   endtask

   task automatic test_normal_spark();
      int sparks;
      logic exp_coil, exp_spk;
      sparks = 0;
      do_reset();
      load_pair(24'd1000, 24'd1200);
      tick();
      checks++;
      if (state_o !== 2'd1) begin
         errors++;
         $display("FAIL normal_armed: state=%0d, want 1", state_o);
      end
      for (int a = 0; a <= 1300; a++) begin
         acnt = 24'(a);
         acnt_vld = 1'b1;
         tick();
         exp_coil = (a >= 1000) && (a < 1200);
         exp_spk = (a == 1200);
         checks++;
         if (coil_out !== exp_coil) begin
            errors++;
            $display("FAIL normal_coil: acnt=%0d coil=%b, want %b", a, coil_out, exp_coil);
         end
         checks++;
         if (spark_pulse !== exp_spk) begin
            errors++;
            $display("FAIL normal_spark_pulse: acnt=%0d spk=%b, want %b", a, spark_pulse, exp_spk);
         end
      end
      acnt_vld = 1'b0;
      checks++;
      if (spark_cnt !== 16'd1) begin
         errors++;
         $display("FAIL normal_spark_cnt: got %0d, want 1", spark_cnt);
      end
      checks++;
      if (dwell_fault !== 1'b0) begin
         errors++;
         $display("FAIL normal_no_fault: dwell_fault=%b, want 0", dwell_fault);
      end
      $display("test_normal_spark: pair (1000,1200) spark_cnt=%0d", spark_cnt);
   endtask

   task automatic test_wrap();
      int a;
      logic exp_coil, exp_spk;
      do_reset();
      load_pair(24'd3800, 24'd100);
      tick();
      for (int i = 0; i <= 340; i++) begin
         a = (i < 140) ? 3700 + i : i - 140;
         acnt = 24'(a);
         acnt_vld = 1'b1;
         tick();
         exp_coil = (a >= 3800) || (a < 100);
         exp_spk = (a == 100);
         checks++;
         if (coil_out !== exp_coil) begin
            errors++;
            $display("FAIL wrap_coil: acnt=%0d coil=%b, want %b", a, coil_out, exp_coil);
         end
         checks++;
         if (spark_pulse !== exp_spk) begin
            errors++;
            $display("FAIL wrap_spark_pulse: acnt=%0d spk=%b, want %b", a, spark_pulse, exp_spk);
         end
      end
      acnt_vld = 1'b0;
      checks++;
      if ({spark_cnt, dwell_fault} !== {16'd1, 1'b0}) begin
         errors++;
         $display("FAIL wrap_result: spark_cnt=%0d df=%b, want 1/0", spark_cnt, dwell_fault);
      end
      $display("test_wrap: pair (3800,100) spark_cnt=%0d", spark_cnt);
   endtask

   task automatic test_max_dwell();
      int fall;
      logic saw_spark;
      fall = -1;
      saw_spark = 1'b0;
      do_reset();
      load_pair(24'd10, 24'd20);
      tick();
      acnt = 24'd10;
      acnt_vld = 1'b1;
      tick();
      acnt_vld = 1'b0;
      checks++;
      if (md_coil_out !== 1'b1) begin
         errors++;
         $display("FAIL dwell_coil_rise: coil=%b, want 1", md_coil_out);
      end
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (md_spark_pulse === 1'b1) saw_spark = 1'b1;
         if (md_coil_out !== 1'b1 && fall < 0) fall = k;
      end
      checks++;
      if (fall != 50) begin
         errors++;
         $display("FAIL dwell_fall_time: coil fell after %0d clks, want 50", fall);
      end
      checks++;
      if (md_dwell_fault !== 1'b1) begin
         errors++;
         $display("FAIL dwell_fault_set: df=%b, want 1", md_dwell_fault);
      end
      checks++;
      if (md_spark_cnt !== 16'd0 || saw_spark) begin
         errors++;
         $display("FAIL dwell_no_spark: spark_cnt=%0d pulse_seen=%b, want 0/0", md_spark_cnt, saw_spark);
      end
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      checks++;
      if (md_dwell_fault !== 1'b0) begin
         errors++;
         $display("FAIL dwell_fault_clr: df=%b, want 0", md_dwell_fault);
      end
      $display("test_max_dwell: coil fell after %0d clks", fall);
   endtask

   task automatic test_update_during_charge();
      logic exp_coil, exp_spk;
      do_reset();
      load_pair(24'd1000, 24'd1200);
      tick();
      for (int a = 0; a <= 2200; a++) begin
         acnt = 24'(a);
         acnt_vld = 1'b1;
         if (a == 1050) begin
            charge_angle = 24'd2000;
            ignition_angle = 24'd2100;
            upd_stb = 1'b1;
         end
         tick();
         upd_stb = 1'b0;
         exp_coil = ((a >= 1000) && (a < 1200)) || ((a >= 2000) && (a < 2100));
         exp_spk = (a == 1200) || (a == 2100);
         checks++;
         if (coil_out !== exp_coil) begin
            errors++;
            $display("FAIL upd_coil: acnt=%0d coil=%b, want %b", a, coil_out, exp_coil);
         end
         checks++;
         if (spark_pulse !== exp_spk) begin
            errors++;
            $display("FAIL upd_spark_pulse: acnt=%0d spk=%b, want %b", a, spark_pulse, exp_spk);
         end
      end
      acnt_vld = 1'b0;
      checks++;
      if (spark_cnt !== 16'd2) begin
         errors++;
         $display("FAIL upd_spark_cnt: got %0d, want 2", spark_cnt);
      end
      $display("test_update_during_charge: (1000,1200) then (2000,2100) spark_cnt=%0d", spark_cnt);
   endtask

   task automatic test_rejection();
      logic exp_coil;
      do_reset();
      load_pair(24'd1000, 24'd1200);
      tick();
      load_pair(24'd4000, 24'd100);
      checks++;
      if (cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL reject_out_of_range: cfg_err=%b, want 1", cfg_err);
      end
      load_pair(24'd500, 24'd500);
      checks++;
      if ({cfg_err, state_o} !== {1'b1, 2'd1}) begin
         errors++;
         $display("FAIL reject_equal: cfg_err=%b state=%0d, want 1/1", cfg_err, state_o);
      end
      for (int a = 0; a <= 1300; a++) begin
         acnt = 24'(a);
         acnt_vld = 1'b1;
         tick();
         exp_coil = (a >= 1000) && (a < 1200);
         checks++;
         if (coil_out !== exp_coil) begin
            errors++;
            $display("FAIL reject_keeps_pair: acnt=%0d coil=%b, want %b", a, coil_out, exp_coil);
         end
      end
      acnt_vld = 1'b0;
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      checks++;
      if (cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL cfg_err_clr: cfg_err=%b, want 0", cfg_err);
      end
      fault_clr = 1'b1;
      load_pair(24'd4000, 24'd10);
      fault_clr = 1'b0;
      checks++;
      if (cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL cfg_err_set_over_clr: cfg_err=%b, want 1", cfg_err);
      end
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      load_pair(24'd3839, 24'd0);
      checks++;
      if (cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL accept_top_angle: cfg_err=%b, want 0", cfg_err);
      end
      tick();
      tick();
      checks++;
      if (state_o !== 2'd1) begin
         errors++;
         $display("FAIL top_pair_armed: state=%0d, want 1", state_o);
      end
      acnt = 24'd3839;
      acnt_vld = 1'b1;
      tick();
      checks++;
      if (coil_out !== 1'b1) begin
         errors++;
         $display("FAIL top_pair_charge: coil=%b, want 1", coil_out);
      end
      acnt = 24'd0;
      tick();
      acnt_vld = 1'b0;
      checks++;
      if ({coil_out, spark_pulse, spark_cnt} !== {1'b0, 1'b1, 16'd2}) begin
         errors++;
         $display("FAIL top_pair_spark: coil=%b spk=%b cnt=%0d, want 0/1/2", coil_out, spark_pulse, spark_cnt);
      end
      $display("test_rejection: (4000,100) and (500,500) rejected, (3839,0) accepted");
   endtask

   task automatic test_run_drop();
      do_reset();
      load_pair(24'd1000, 24'd1200);
      tick();
      for (int a = 990; a <= 1050; a++) begin
         acnt = 24'(a);
         acnt_vld = 1'b1;
         tick();
      end
      acnt_vld = 1'b0;
      checks++;
      if (coil_out !== 1'b1) begin
         errors++;
         $display("FAIL run_drop_precond: coil=%b, want 1", coil_out);
      end
      run = 1'b0;
      tick();
      checks++;
      if ({coil_out, spark_pulse, state_o} !== {1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL run_drop_off: coil=%b spk=%b state=%0d, want 0/0/0", coil_out, spark_pulse, state_o);
      end
      tick();
      tick();
      checks++;
      if ({spark_cnt, dwell_fault} !== {16'd0, 1'b0}) begin
         errors++;
         $display("FAIL run_drop_no_spark: cnt=%0d df=%b, want 0/0", spark_cnt, dwell_fault);
      end
      run = 1'b1;
      tick();
      checks++;
      if (state_o !== 2'd1) begin
         errors++;
         $display("FAIL run_resume_armed: state=%0d, want 1", state_o);
      end
      acnt = 24'd1000;
      acnt_vld = 1'b1;
      tick();
      checks++;
      if (coil_out !== 1'b1) begin
         errors++;
         $display("FAIL run_resume_charge: coil=%b, want 1", coil_out);
      end
      acnt = 24'd1200;
      tick();
      acnt_vld = 1'b0;
      checks++;
      if ({coil_out, spark_cnt} !== {1'b0, 16'd1}) begin
         errors++;
         $display("FAIL run_resume_spark: coil=%b cnt=%0d, want 0/1", coil_out, spark_cnt);
      end
      $display("test_run_drop: coil dropped, pair retained, spark_cnt=%0d", spark_cnt);
   endtask

   task automatic test_reset_mid_charge();
      do_reset();
      load_pair(24'd1000, 24'd1200);
      tick();
      acnt = 24'd1000; acnt_vld = 1'b1; tick();
      acnt = 24'd1200; tick();
      acnt_vld = 1'b0;
      load_pair(24'd4000, 24'd1);
      acnt = 24'd1000; acnt_vld = 1'b1; tick();
      acnt_vld = 1'b0;
      checks++;
      if ({coil_out, spark_cnt, cfg_err} !== {1'b1, 16'd1, 1'b1}) begin
         errors++;
         $display("FAIL reset_mid_precond: coil=%b cnt=%0d ce=%b, want 1/1/1", coil_out, spark_cnt, cfg_err);
      end
      #2;
      nrst = 1'b0;
      #1;
      checks++;
      if ({coil_out, spark_pulse, spark_cnt, dwell_fault, cfg_err, state_o} !== 21'd0) begin
         errors++;
         $display("FAIL reset_mid_async: coil=%b spk=%b cnt=%0d df=%b ce=%b st=%0d, want all 0",
                  coil_out, spark_pulse, spark_cnt, dwell_fault, cfg_err, state_o);
      end
      tick();
      nrst = 1'b1;
      run = 1'b1;
      tick();
      tick();
      checks++;
      if (state_o !== 2'd0) begin
         errors++;
         $display("FAIL reset_mid_pairs_cleared: state=%0d, want 0", state_o);
      end
      $display("test_reset_mid_charge: async reset cleared channel");
   endtask

   initial begin
      test_reset();
      test_normal_spark();
      test_wrap();
      test_max_dwell();
      test_update_during_charge();
      test_rejection();
      test_run_drop();
      test_reset_mid_charge();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
